// File: rtl/bus_burst_ram_slave.sv
// Burst-bus target owning a 512 x 32 RAM window at baseAddress.
// Optional misaligned-address error response: BUS_BURST_RAM_SLAVE_ERROR_EN.
module bus_burst_ram_slave #(
  parameter logic [31:0] baseAddress = 32'h5000_0000,
  parameter int          nrOfWords   = 512
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_data_in,
  input  logic [3:0]  byte_enables_in,
  input  logic [7:0]  burst_size_in,
  input  logic        read_n_write_in,
  input  logic        begin_transaction_in,
  input  logic        end_transaction_in,
  input  logic        data_valid_in,
  output logic [31:0] address_data_out,
  output logic        data_valid_out,
  output logic        end_transaction_out,
  output logic        error_out
);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, RD_END, WR_DATA, ERR, ERR_END
  } state_t;

  state_t      state, state_next;
  logic [8:0]  word_ptr;
  logic [8:0]  remaining;
  logic [3:0]  be_q;
  logic [31:0] mem [nrOfWords];

  logic window, hit, load, rd_beat, wr_en, end_next;

  assign window = begin_transaction_in &&
                  (address_data_in[31:11] == baseAddress[31:11]);

`ifdef BUS_BURST_RAM_SLAVE_ERROR_EN
  logic err_next;
  assign hit = window && (address_data_in[1:0] == 2'b00);
`else
  assign hit = window;
`endif

  always_comb begin
    state_next = state;
    load       = 1'b0;
    rd_beat    = 1'b0;
    wr_en      = 1'b0;
    end_next   = 1'b0;
`ifdef BUS_BURST_RAM_SLAVE_ERROR_EN
    err_next   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (hit) begin
          load       = 1'b1;
          state_next = read_n_write_in ? RD_ADDR : WR_DATA;
        end
`ifdef BUS_BURST_RAM_SLAVE_ERROR_EN
        else if (window) begin
          err_next   = 1'b1;
          state_next = ERR;
        end
`endif
      end
      RD_ADDR: begin
        rd_beat    = 1'b1;
        state_next = RD_DATA;
      end
      // remaining counts beats still to be fetched; zero means the last beat is on the bus
      RD_DATA: begin
        if (remaining != 9'd0) begin
          rd_beat = 1'b1;
        end else begin
          end_next   = 1'b1;
          state_next = RD_END;
        end
      end
      RD_END:  state_next = IDLE;
      WR_DATA: begin
        wr_en = data_valid_in && (remaining != 9'd0);
        if (end_transaction_in) state_next = IDLE;
      end
      ERR: begin
        end_next   = 1'b1;
        state_next = ERR_END;
      end
      ERR_END: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= IDLE;
      word_ptr            <= 9'd0;
      remaining           <= 9'd0;
      be_q                <= 4'd0;
      address_data_out    <= 32'd0;
      data_valid_out      <= 1'b0;
      end_transaction_out <= 1'b0;
    end else begin
      state <= state_next;
      if (load) begin
        word_ptr  <= address_data_in[10:2];
        remaining <= {1'b0, burst_size_in} + 9'd1;
        be_q      <= byte_enables_in;
      end else if (rd_beat || wr_en) begin
        word_ptr  <= word_ptr + 9'd1;
        remaining <= remaining - 9'd1;
      end
      data_valid_out      <= rd_beat;
      address_data_out    <= rd_beat ? mem[word_ptr] : 32'd0;
      end_transaction_out <= end_next;
    end
  end

  // RAM contents survive reset; only the write strobe is gated
  always_ff @(posedge clock) begin
    if (wr_en && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[word_ptr][8*i +: 8] <= address_data_in[8*i +: 8];
      end
    end
  end

`ifdef BUS_BURST_RAM_SLAVE_ERROR_EN
  always_ff @(posedge clock) begin
    if (reset) error_out <= 1'b0;
    else       error_out <= err_next;
  end
`else
  assign error_out = 1'b0;
`endif

endmodule

// File: tb/tb_bus_burst_ram_slave.sv
// Scoreboard bench for bus_burst_ram_slave: randomized bus traffic against a word-array model.
module tb_bus_burst_ram_slave;
  localparam logic [31:0] BASE = 32'h5000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] address_data_in;
  logic [3:0]  byte_enables_in;
  logic [7:0]  burst_size_in;
  logic        read_n_write_in;
  logic        begin_transaction_in;
  logic        end_transaction_in;
  logic        data_valid_in;
  logic [31:0] address_data_out;
  logic        data_valid_out;
  logic        end_transaction_out;
  logic        error_out;

  bus_burst_ram_slave #(.baseAddress(BASE), .nrOfWords(512)) dut (
    .clock(clock), .reset(reset),
    .address_data_in(address_data_in), .byte_enables_in(byte_enables_in),
    .burst_size_in(burst_size_in), .read_n_write_in(read_n_write_in),
    .begin_transaction_in(begin_transaction_in), .end_transaction_in(end_transaction_in),
    .data_valid_in(data_valid_in), .address_data_out(address_data_out),
    .data_valid_out(data_valid_out), .end_transaction_out(end_transaction_out),
    .error_out(error_out)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          at;
    logic        dv;
    logic [31:0] data;
    logic        et;
    logic        er;
  } exp_t;

  exp_t        q[$];
  logic [31:0] ref_mem [512];
  logic [31:0] wdata [256];
  int          n_checks = 0;
  int          n_fail = 0;

  // Monitor: every cycle, either an expected response is due or the bus must be silent.
  always @(negedge clock) begin
    exp_t e;
    if (q.size() > 0 && q[0].at == cyc) begin
      e = q.pop_front();
      n_checks++;
      if (data_valid_out !== e.dv || address_data_out !== e.data ||
          end_transaction_out !== e.et || error_out !== e.er) begin
        n_fail++;
        $display("FAIL response cyc=%0d got dv=%b data=%h et=%b er=%b expected dv=%b data=%h et=%b er=%b",
                 cyc, data_valid_out, address_data_out, end_transaction_out, error_out,
                 e.dv, e.data, e.et, e.er);
      end
    end else if (data_valid_out !== 1'b0 || address_data_out !== 32'd0 ||
                 end_transaction_out !== 1'b0 || error_out !== 1'b0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_output cyc=%0d got dv=%b data=%h et=%b er=%b expected all zero",
               cyc, data_valid_out, address_data_out, end_transaction_out, error_out);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    address_data_in      = 32'd0;
    byte_enables_in      = 4'd0;
    burst_size_in        = 8'd0;
    read_n_write_in      = 1'b0;
    begin_transaction_in = 1'b0;
    end_transaction_in   = 1'b0;
    data_valid_in        = 1'b0;
  endtask

  task automatic check_quiet(input string name);
    n_checks++;
    if (data_valid_out !== 1'b0 || address_data_out !== 32'd0 ||
        end_transaction_out !== 1'b0 || error_out !== 1'b0) begin
      n_fail++;
      $display("FAIL %s got dv=%b data=%h et=%b er=%b expected all zero",
               name, data_valid_out, address_data_out, end_transaction_out, error_out);
    end
  endtask

  function automatic logic [31:0] win_addr(input int word, input int low);
    return BASE + 32'((word % 512) * 4) + 32'(low);
  endfunction

  // Write burst of n beats from wdata[]; random gaps, optional surplus beat, end with or after last beat.
  task automatic do_write(input int word, input int n, input logic [3:0] be, input int low);
    int  c;
    bit  ended;
    bit  applies;
    int  idx;
    c = cyc;
    applies = 1'b1;
`ifdef BUS_BURST_RAM_SLAVE_ERROR_EN
    if (low % 4 != 0) begin
      applies = 1'b0;
      q.push_back('{c + 1, 1'b0, 32'd0, 1'b0, 1'b1});
      q.push_back('{c + 2, 1'b0, 32'd0, 1'b1, 1'b0});
    end
`endif
    begin_transaction_in = 1'b1;
    address_data_in      = win_addr(word, low);
    burst_size_in        = 8'(n - 1);
    read_n_write_in      = 1'b0;
    byte_enables_in      = be;
    tick();
    begin_transaction_in = 1'b0;
    byte_enables_in      = 4'($urandom);
    burst_size_in        = 8'($urandom);
    ended = 1'b0;
    for (int k = 0; k < n; k++) begin
      while ($urandom_range(0, 3) == 0) begin
        data_valid_in   = 1'b0;
        address_data_in = $urandom;
        tick();
      end
      data_valid_in   = 1'b1;
      address_data_in = wdata[k];
      if (applies) begin
        idx = (word + k) % 512;
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[idx][8*b +: 8] = wdata[k][8*b +: 8];
      end
      if (k == n - 1 && $urandom_range(0, 1) == 1) begin
        end_transaction_in = 1'b1;
        ended = 1'b1;
      end
      tick();
    end
    if (!ended) begin
      if ($urandom_range(0, 1) == 1) begin
        data_valid_in   = 1'b1;
        address_data_in = $urandom;
        tick();
      end
      data_valid_in      = 1'b0;
      end_transaction_in = 1'b1;
      tick();
    end
    idle_inputs();
  endtask

  task automatic do_read(input int word, input int n, input int low);
    int c;
    c = cyc;
    begin_transaction_in = 1'b1;
    address_data_in      = win_addr(word, low);
    burst_size_in        = 8'(n - 1);
    read_n_write_in      = 1'b1;
    byte_enables_in      = 4'($urandom);
`ifdef BUS_BURST_RAM_SLAVE_ERROR_EN
    if (low % 4 != 0) begin
      q.push_back('{c + 1, 1'b0, 32'd0, 1'b0, 1'b1});
      q.push_back('{c + 2, 1'b0, 32'd0, 1'b1, 1'b0});
      tick();
      idle_inputs();
      repeat (3) tick();
      return;
    end
`endif
    for (int k = 0; k < n; k++)
      q.push_back('{c + 2 + k, 1'b1, ref_mem[(word + k) % 512], 1'b0, 1'b0});
    q.push_back('{c + 2 + n, 1'b0, 32'd0, 1'b1, 1'b0});
    tick();
    // stray end and begin strobes while busy must be ignored
    for (int k = 0; k < n + 2; k++) begin
      end_transaction_in   = 1'($urandom_range(0, 1));
      begin_transaction_in = ($urandom_range(0, 7) == 0);
      address_data_in      = BASE + (32'($urandom_range(0, 2047)) & 32'h7FC);
      read_n_write_in      = 1'($urandom_range(0, 1));
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    int c;
    int word;
    int n;
    idle_inputs();
    reset = 1'b1;
    repeat (3) tick();
    check_quiet("reset_state");
    reset = 1'b0;
    tick();

    // Fill the whole RAM so every later read has a defined model value (includes 256-beat bursts).
    for (int h = 0; h < 2; h++) begin
      for (int k = 0; k < 256; k++) wdata[k] = $urandom;
      do_write(h * 256, 256, 4'hF, 0);
    end
    do_read(100, 8, 0);

    wdata[0] = 32'hDEAD_BEEF;
    do_write(4, 1, 4'hF, 0);
    do_read(4, 1, 0);

    for (int k = 0; k < 8; k++) wdata[k] = 32'h100 + 32'(k);
    do_write(0, 8, 4'hF, 0);
    do_read(0, 8, 0);

    wdata[0] = 32'h1122_3344;
    do_write(5, 1, 4'hF, 0);
    wdata[0] = 32'hAABB_CCDD;
    do_write(5, 1, 4'b0101, 0);
    do_read(5, 1, 0);

    for (int k = 0; k < 4; k++) wdata[k] = 32'(k + 1);
    do_write(510, 4, 4'hF, 0);
    do_read(510, 4, 0);
    do_read(384, 256, 0);

    // Out-of-window begin: the bus must stay silent (monitor flags any activity).
    begin_transaction_in = 1'b1;
    address_data_in      = BASE + 32'h800;
    burst_size_in        = 8'd3;
    read_n_write_in      = 1'b1;
    tick();
    idle_inputs();
    repeat (10) tick();
    check_quiet("miss_quiet");

    // Reset during the third beat of a 16-beat read.
    c = cyc;
    begin_transaction_in = 1'b1;
    address_data_in      = win_addr(20, 0);
    burst_size_in        = 8'd15;
    read_n_write_in      = 1'b1;
    for (int k = 0; k < 3; k++)
      q.push_back('{c + 2 + k, 1'b1, ref_mem[20 + k], 1'b0, 1'b0});
    tick();
    idle_inputs();
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_quiet("reset_mid_read");
    do_read(30, 5, 0);

    // Misaligned in-window accesses: error response or plain hit depending on build.
    do_read(3, 4, 2);
    for (int k = 0; k < 3; k++) wdata[k] = $urandom;
    do_write(7, 3, 4'hF, 1);
    do_read(7, 3, 0);

    for (int t = 0; t < 30; t++) begin
      word = $urandom_range(0, 511);
      n    = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 256) : $urandom_range(1, 16);
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < n; k++) wdata[k] = $urandom;
        do_write(word, n, 4'($urandom), 0);
      end else begin
        do_read(word, n, 0);
      end
    end

    for (int i = 0; i < 50 && q.size() > 0; i++) tick();
    n_checks++;
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending responses expected 0", q.size());
    end
    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got no completion expected finish before limit");
    $fatal(1);
  end
endmodule
